// File: rtl/wr_port_arb_8_pkg.sv
// Shared types and constants for the 8-port write arbiter.
package wr_port_arb_8_pkg;

  localparam int NUM_PORTS_DEF = 8;
  localparam int PORT_IDX_W    = 3;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Next port index in round-robin order, wrapping from the last port to 0.
  function automatic logic [PORT_IDX_W-1:0] idx_inc(input logic [PORT_IDX_W-1:0] idx);
    return (idx == PORT_IDX_W'(NUM_PORTS_DEF - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/wr_port_arb_8_if.sv
// Requester-facing bundle: request/lock in, one-hot grant and mux select out.
interface wr_port_arb_8_if
  import wr_port_arb_8_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF
) ();

  logic [NUM_PORTS-1:0] port_req;
  logic [NUM_PORTS-1:0] port_lock;
  logic [NUM_PORTS-1:0] port_grant;
  logic [NUM_PORTS-1:0] select;

  // Requester side drives req/lock and observes the grant.
  modport master (
    output port_req,
    output port_lock,
    input  port_grant,
    input  select
  );

  // Arbiter side.
  modport slave (
    input  port_req,
    input  port_lock,
    output port_grant,
    output select
  );

endinterface

// File: rtl/wr_port_arb_8_rr_find_first.sv
// Rotate-and-find-first: one-hot of the first set req bit at or after start.
module rr_find_first_8
  import wr_port_arb_8_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] start,
  output logic [NUM_PORTS-1:0]  grant_oh
);

  logic                  found;
  logic [PORT_IDX_W-1:0] idx;

  // Scan start, start+1, ... with the index wrapping naturally at 8 ports.
  always_comb begin
    grant_oh = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = start + PORT_IDX_W'(i);
      if (!found && req[idx]) begin
        grant_oh[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wr_port_arb_8.sv
// Round-robin write-port arbiter with bounded multi-beat lock.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARB    | round-robin search from rr_ptr, grant in the same cycle
// ST_LOCKED | only owner may transfer; leaves on unlock, MAX_LOCK beats,
//           | or owner dropping its request
module wr_port_arb_8
  import wr_port_arb_8_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int MAX_LOCK  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wr_port_arb_8_if.slave        bus,
  output logic                  locked,
  output logic [PORT_IDX_W-1:0] rr_ptr
);

  localparam int BEAT_W = $clog2(MAX_LOCK + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_LOCK);
  // A single-beat limit makes locking meaningless, so lock requests are ignored.
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  arb_state_e            state_q,  state_d;
  logic [PORT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_IDX_W-1:0] owner_q,  owner_d;
  logic [BEAT_W-1:0]     beat_q,   beat_d;

  logic [NUM_PORTS-1:0]  arb_grant;
  logic [NUM_PORTS-1:0]  grant_c;
  logic [PORT_IDX_W-1:0] g_idx;
  logic [BEAT_W-1:0]     beat_inc;

  rr_find_first_8 #(
    .NUM_PORTS (NUM_PORTS)
  ) u_find (
    .req      (bus.port_req),
    .start    (rr_ptr_q),
    .grant_oh (arb_grant)
  );

  // Encode the round-robin winner so the FSM can record owner and pointer.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant[PORT_IDX_W'(i)]) g_idx = PORT_IDX_W'(i);
    end
  end

  // Same-cycle grant; reset gates it so the mux sees no write enable.
  always_comb begin
    grant_c = '0;
    if (state_q == ST_ARB) begin
      grant_c = arb_grant;
    end else begin
      grant_c[owner_q] = bus.port_req[owner_q];
    end
    if (!rst_n) grant_c = '0;
  end

  assign bus.port_grant = grant_c;
  assign bus.select     = grant_c;
  assign locked         = (state_q == ST_LOCKED);
  assign rr_ptr         = rr_ptr_q;

  // Beat count never exceeds MAX_LOCK while locked, so this cannot overflow.
  assign beat_inc = beat_q + 1'b1;

  // Next-state: pointer advance, lock entry and the three lock exits.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    unique case (state_q)
      ST_ARB: begin
        if (|arb_grant) begin
          if (LOCK_EN && bus.port_lock[g_idx]) begin
            state_d = ST_LOCKED;
            owner_d = g_idx;
            beat_d  = BEAT_W'(1);
          end else begin
            rr_ptr_d = idx_inc(g_idx);
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.port_req[owner_q]) begin
          state_d  = ST_ARB;
          rr_ptr_d = idx_inc(owner_q);
          beat_d   = '0;
        end else if (!bus.port_lock[owner_q] || beat_inc == BEAT_MAX) begin
          state_d  = ST_ARB;
          rr_ptr_d = idx_inc(owner_q);
          beat_d   = '0;
        end else begin
          beat_d = beat_inc;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_wr_port_arb_8.sv
// Directed and random checks for wr_port_arb_8 (MAX_LOCK=4 and MAX_LOCK=1).
module tb_wr_port_arb_8;
  import wr_port_arb_8_pkg::*;

  logic clk;
  logic rst_n;
  logic                  locked0, locked1;
  logic [PORT_IDX_W-1:0] rr_ptr0, rr_ptr1;

  int total;
  int passed;
  int fails;
  int wait_cnt [8];
  int max_wait;

  wr_port_arb_8_if bus0 ();
  wr_port_arb_8_if bus1 ();

  wr_port_arb_8 #(.MAX_LOCK(4)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus0),
    .locked (locked0),
    .rr_ptr (rr_ptr0)
  );

  wr_port_arb_8 #(.MAX_LOCK(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus1),
    .locked (locked1),
    .rr_ptr (rr_ptr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1ns later.
  task automatic step0(input logic [7:0] req, input logic [7:0] lock);
    @(negedge clk);
    bus0.port_req  = req;
    bus0.port_lock = lock;
    #1;
  endtask

  task automatic step1(input logic [7:0] req, input logic [7:0] lock);
    @(negedge clk);
    bus1.port_req  = req;
    bus1.port_lock = lock;
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus0.port_req  = 8'hFF;
    bus0.port_lock = 8'h00;
    bus1.port_req  = 8'h00;
    bus1.port_lock = 8'h00;

    // Reset state, with requests present.
    @(negedge clk);
    #1;
    check("rst_grant",  32'(bus0.port_grant), 32'h00);
    check("rst_select", 32'(bus0.select),     32'h00);
    check("rst_locked", 32'(locked0),         32'h0);
    check("rst_rr_ptr", 32'(rr_ptr0),         32'h0);

    // All ports requesting: grants rotate 01..80, pointer back to 0.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sweep_g0", 32'(bus0.port_grant), 32'h01);
    step0(8'hFF, 8'h00); check("sweep_g1", 32'(bus0.port_grant), 32'h02);
    step0(8'hFF, 8'h00); check("sweep_g2", 32'(bus0.port_grant), 32'h04);
    step0(8'hFF, 8'h00); check("sweep_g3", 32'(bus0.port_grant), 32'h08);
    step0(8'hFF, 8'h00); check("sweep_g4", 32'(bus0.port_grant), 32'h10);
    step0(8'hFF, 8'h00); check("sweep_g5", 32'(bus0.port_grant), 32'h20);
    step0(8'hFF, 8'h00); check("sweep_g6", 32'(bus0.port_grant), 32'h40);
    step0(8'hFF, 8'h00); check("sweep_g7", 32'(bus0.port_grant), 32'h80);
    check("sweep_sel7", 32'(bus0.select), 32'h80);
    step0(8'h00, 8'h00);
    check("sweep_rr_end", 32'(rr_ptr0), 32'h0);
    check("idle_grant",   32'(bus0.port_grant), 32'h00);

    // Steer pointer to 6, then wrap from port 6 to port 0.
    step0(8'h20, 8'h00); check("steer_g5", 32'(bus0.port_grant), 32'h20);
    step0(8'h41, 8'h00);
    check("wrap_rr6", 32'(rr_ptr0), 32'h6);
    check("wrap_g6",  32'(bus0.port_grant), 32'h40);
    step0(8'h41, 8'h00); check("wrap_g0", 32'(bus0.port_grant), 32'h01);
    check("wrap_rr7", 32'(rr_ptr0), 32'h7);

    // Port 3 locks for MAX_LOCK=4 beats while port 5 waits.
    step0(8'h28, 8'h08);
    check("lk3_b1",     32'(bus0.port_grant), 32'h08);
    check("lk3_unlk1",  32'(locked0), 32'h0);
    step0(8'h28, 8'h08);
    check("lk3_b2",     32'(bus0.port_grant), 32'h08);
    check("lk3_locked", 32'(locked0), 32'h1);
    step0(8'h28, 8'h08); check("lk3_b3", 32'(bus0.port_grant), 32'h08);
    step0(8'h28, 8'h08); check("lk3_b4", 32'(bus0.port_grant), 32'h08);
    step0(8'h28, 8'h08);
    check("lk3_forced_rel", 32'(locked0), 32'h0);
    check("lk3_rr4",        32'(rr_ptr0), 32'h4);
    check("lk3_then_g5",    32'(bus0.port_grant), 32'h20);

    // Port 2 locks, then abandons the burst at beat 2.
    step0(8'h04, 8'h04); check("ab2_b1", 32'(bus0.port_grant), 32'h04);
    step0(8'h04, 8'h04);
    check("ab2_b2",     32'(bus0.port_grant), 32'h04);
    check("ab2_locked", 32'(locked0), 32'h1);
    step0(8'h00, 8'h04);
    check("ab2_zero",     32'(bus0.port_grant), 32'h00);
    check("ab2_still_lk", 32'(locked0), 32'h1);
    step0(8'hFF, 8'h00);
    check("ab2_unlk", 32'(locked0), 32'h0);
    check("ab2_rr3",  32'(rr_ptr0), 32'h3);
    check("ab2_g3",   32'(bus0.port_grant), 32'h08);

    // Reset asserted in the middle of a port 6 burst.
    step0(8'h40, 8'h40); check("rb_g6", 32'(bus0.port_grant), 32'h40);
    step0(8'h40, 8'h40);
    check("rb_locked", 32'(locked0), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_grant0",  32'(bus0.port_grant), 32'h00);
    check("rb_select0", 32'(bus0.select),     32'h00);
    check("rb_unlk",    32'(locked0), 32'h0);
    check("rb_rr0",     32'(rr_ptr0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.port_req  = 8'hF0;
    bus0.port_lock = 8'h00;
    #1;
    check("rb_first_g4", 32'(bus0.port_grant), 32'h10);

    // MAX_LOCK=1: lock requests have no effect.
    step1(8'h0C, 8'h0C);
    check("ml1_g2",  32'(bus1.port_grant), 32'h04);
    check("ml1_lk0", 32'(locked1), 32'h0);
    step1(8'h0C, 8'h0C);
    check("ml1_g3",  32'(bus1.port_grant), 32'h08);
    check("ml1_lk1", 32'(locked1), 32'h0);
    step1(8'h0C, 8'h0C);
    check("ml1_g2b", 32'(bus1.port_grant), 32'h04);

    // Random stream: one-hot-or-zero, select tracks grant, grant within req, bounded wait.
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step0(8'($urandom), 8'($urandom));
      check("rnd_onehot0",  32'($onehot0(bus0.port_grant)), 32'h1);
      check("rnd_select",   32'(bus0.select), 32'(bus0.port_grant));
      check("rnd_in_req",   32'(bus0.port_grant & ~bus0.port_req), 32'h0);
      max_wait = 0;
      for (int p = 0; p < 8; p++) begin
        if (bus0.port_req[p] && !bus0.port_grant[p]) wait_cnt[p]++;
        else wait_cnt[p] = 0;
        if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
      end
      check("rnd_wait_bound", 32'(max_wait <= 32), 32'h1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
